bs_rr_arbiter: RTL
==================

BS_RR_ARBITER -- requirements
Module: bs_rr_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- drvrs, 4, number of attached driver/receiver ports (2..16).
- pckg_sz, 16, packet width in bits (>= 9).
- broadcast, 8'hFF, destination ID that delivers a packet to every port except its source.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- pndng, input, drvrs, per-port "FIFO head holds a packet".
- D_pop, input, drvrs*pckg_sz, per-port head packet; port i occupies bits [i*pckg_sz +: pckg_sz].
- pop, output, drvrs, one-hot; dequeues the head of the granted port.
- push, output, drvrs, write strobe mask to receiving ports.
- D_push, output, pckg_sz, shared bus data presented to all ports.
- drop, output, 1, one-cycle pulse when a packet is discarded.

Function
REQ-003 The block SHALL implement FSM states IDLE, GRANT and SEND.
REQ-004 IDLE: when pndng != 0, the block SHALL select a winner, register its index and move to GRANT; otherwise it SHALL stay in IDLE.
REQ-005 ARB_MODE=0: the winner SHALL be the lowest set index of pndng.
REQ-006 ARB_MODE=1: the block SHALL search pndng starting at rr_ptr and wrap modulo drvrs; after each pop, rr_ptr SHALL become (grant+1) mod drvrs.
REQ-007 GRANT, when pndng[grant]=1: the block SHALL assert pop[grant] for exactly one cycle, latch the D_pop slice of the granted port into pkt_reg, and move to SEND.
REQ-008 GRANT, when pndng[grant]=0: the block SHALL not pop, SHALL leave rr_ptr unchanged, and SHALL return to IDLE.
REQ-009 The destination SHALL be dest = pkt_reg[pckg_sz-1 -: 8].
REQ-010 SEND: D_push SHALL equal pkt_reg, asserted for one cycle, after which the FSM SHALL return to IDLE.
- dest < drvrs: push SHALL equal the one-hot of dest; dest == source is permitted.
- dest == broadcast: push SHALL have all bits set except the source bit.
- otherwise: push SHALL be 0 and drop SHALL be 1.
REQ-011 Latency SHALL be as follows:
- pop SHALL assert 2 cycles after pndng is first seen in IDLE.
- push SHALL assert 1 cycle after pop.
- Peak throughput SHALL be one packet per 3 cycles.
REQ-012 pop, push and drop SHALL be registered outputs with no combinational path from any input.
REQ-013 Changes on pndng during GRANT or SEND SHALL not affect the transaction in flight.
REQ-014 D_push SHALL hold its last value outside SEND.

Reset
REQ-015 While reset=1, regardless of clk, the block SHALL hold the following values:
- state SHALL be IDLE.
- pop, push and drop SHALL be 0.
- D_push and pkt_reg SHALL be 0.
- rr_ptr SHALL be 0.
REQ-016 Reset asserted mid-transaction SHALL abort it without a push; after release, arbitration SHALL restart from port 0.

Configuration
REQ-017 With BS_ARB_STATS_EN defined, the block SHALL add the following outputs, reset to 0 and wrapping at 2^32-1:
- pkt_cnt [31:0], incremented once per SEND with push != 0.
- drop_cnt [31:0], incremented once per drop.
REQ-018 Without BS_ARB_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification (drvrs=4, pckg_sz=16, broadcast=8'hFF)
REQ-019 Reset: assert reset with pndng=4'b1111 -> pop=0, push=0, D_push=0, drop=0 throughout.
REQ-020 Unicast: pndng=4'b0010, port-1 D_pop=16'h02AB -> pop=4'b0010 at cycle 2, then push=4'b0100 with D_push=16'h02AB at cycle 3.
REQ-021 Broadcast: port 3 sends 16'hFF55 -> push=4'b0111, D_push=16'hFF55.
REQ-022 Fairness: pndng=4'b1111 held for 15 cycles -> with ARB_MODE=1, grants are 0,1,2,3,0; with ARB_MODE=0, grants are 0,0,0,0,0.
REQ-023 Invalid destination: port 0 sends 16'h0911 -> push=0 and drop=1 for one cycle; with BS_ARB_STATS_EN, drop_cnt=1 and pkt_cnt=0.
REQ-024 Abort: assert reset during SEND for 16'h0133 -> push falls to 0 asynchronously; with pndng=4'b1111 after release, the first grant is port 0.

Source files
------------

// File: rtl/bs_rr_arbiter.sv
// Shared-bus arbiter: picks one pending port, pops its head packet and pushes it to the
// destination port(s). Define BS_ARB_STATS_EN to add the pkt_cnt/drop_cnt statistics outputs.
module bs_rr_arbiter #(
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int unsigned ARB_MODE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     drop
`ifdef BS_ARB_STATS_EN
    ,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              drop_cnt
`endif
);

    localparam int unsigned IW = $clog2(drvrs);
    localparam logic [IW-1:0] LastPort = IW'(drvrs - 1);

    typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

    state_t             state;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      next_ptr;
    logic [pckg_sz-1:0] pkt_reg;
    logic [pckg_sz-1:0] sel_pkt;
    logic [drvrs-1:0]   grant_oh;
    logic [drvrs-1:0]   push_mask;
    logic [7:0]         dest;
    logic [31:0]        dest_u;
    logic               is_unicast;
    logic               is_bcast;
    logic               drop_c;

    // Lowest pending index overall, then overridden by the lowest pending index at or
    // above rr_ptr: this yields a wrap-around search starting at rr_ptr.
    always_comb begin
        winner = '0;
        for (int i = drvrs - 1; i >= 0; i--) begin
            if (pndng[i]) winner = IW'(i);
        end
        if (ARB_MODE == 1) begin
            for (int i = drvrs - 1; i >= 0; i--) begin
                if (pndng[i] && (IW'(i) >= rr_ptr)) winner = IW'(i);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_pkt  = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            grant_oh[i] = (IW'(i) == grant);
            if (grant_oh[i]) sel_pkt = D_pop[i*pckg_sz +: pckg_sz];
        end
    end

    assign next_ptr = (grant == LastPort) ? '0 : grant + 1'b1;

    assign dest       = pkt_reg[pckg_sz-1 -: 8];
    assign dest_u     = {24'd0, dest};
    assign is_unicast = (dest_u < drvrs);
    assign is_bcast   = !is_unicast && (dest == broadcast);
    assign drop_c     = !is_unicast && !is_bcast;

    always_comb begin
        push_mask = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (is_unicast)    push_mask[i] = (dest_u == i);
            else if (is_bcast) push_mask[i] = !grant_oh[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            pkt_reg  <= '0;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            drop     <= 1'b0;
`ifdef BS_ARB_STATS_EN
            pkt_cnt  <= '0;
            drop_cnt <= '0;
`endif
        end else begin
            pop  <= '0;
            push <= '0;
            drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|pndng) begin
                        grant <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // The request may have been withdrawn since IDLE; abandon without popping.
                    if (|(pndng & grant_oh)) begin
                        pop     <= grant_oh;
                        pkt_reg <= sel_pkt;
                        rr_ptr  <= next_ptr;
                        state   <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    push   <= push_mask;
                    D_push <= pkt_reg;
                    drop   <= drop_c;
`ifdef BS_ARB_STATS_EN
                    if (drop_c)          drop_cnt <= drop_cnt + 32'd1;
                    else if (|push_mask) pkt_cnt  <= pkt_cnt + 32'd1;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
